// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO with first-word-fall-through read port, fill flags and sticky overflow.
// Optional idle timeout is built only when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_fifo #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned DEPTH_LOG2   = 4,
  parameter int unsigned AFULL_THRESH = 12
`ifdef UART_RX_FIFO_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC  = 1024
`endif
) (
  input  logic              clk_i,
  input  logic              rstb_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_valid_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [DEPTH_LOG2:0] count_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              afull_o,
  output logic              overflow_o,
  input  logic              ovf_clr_i,
  output logic              timeout_o
);

  localparam int unsigned PtrW  = DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;
  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
  localparam logic [CntW-1:0] AfullCnt = CntW'(AFULL_THRESH);

  logic [DATA_W-1:0] mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              empty_q, full_q, afull_q, ovf_q, ovf_d;
  logic              push, pop, drop;

  assign pop  = ~empty_q & rd_ready_i;
  // A pop frees the slot this edge, so a full FIFO can still take a write alongside it.
  assign push = wr_valid_i & (~full_q | pop);
  assign drop = wr_valid_i & full_q & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (pop && !push) count_d = count_q - CntW'(1);
    if (ovf_clr_i) ovf_d = 1'b0;
    if (drop)      ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rstb_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == DepthCnt);
      afull_q  <= (count_d >= AfullCnt);
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rstb_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o  = mem_q[rd_ptr_q];
  assign rd_valid_o = ~empty_q;
  assign count_o    = count_q;
  assign empty_o    = empty_q;
  assign full_o     = full_q;
  assign afull_o    = afull_q;
  assign overflow_o = ovf_q;

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int unsigned IdleW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(TIMEOUT_CYC);

  logic [IdleW-1:0] idle_q, idle_d;

  always_comb begin
    idle_d = idle_q;
    if (push || count_d == '0) idle_d = '0;
    else if (idle_q != IdleMax) idle_d = idle_q + IdleW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rstb_i) idle_q <= '0;
    else        idle_q <= idle_d;
  end

  assign timeout_o = ~empty_q & (idle_q == IdleMax);
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: ordering, full/drop/overflow, push+pop on full,
// fall-through latency, mid-stream reset and the idle timeout.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rstb;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [4:0] count;
  logic       empty, full, afull, overflow, ovf_clr, timeout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DATA_W      (8),
    .DEPTH_LOG2  (4),
    .AFULL_THRESH(12)
`ifdef UART_RX_FIFO_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (8)
`endif
  ) dut (
    .clk_i     (clk),
    .rstb_i    (rstb),
    .wr_data_i (wr_data),
    .wr_valid_i(wr_valid),
    .rd_data_o (rd_data),
    .rd_valid_o(rd_valid),
    .rd_ready_i(rd_ready),
    .count_o   (count),
    .empty_o   (empty),
    .full_o    (full),
    .afull_o   (afull),
    .overflow_o(overflow),
    .ovf_clr_i (ovf_clr),
    .timeout_o (timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rstb = 1'b1; wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0; ovf_clr = 1'b0;
    step(); step();
    rstb = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_afull", 32'(afull), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_timeout", 32'(timeout), 0);

    // Three bytes, then drain in order
    wr_valid = 1'b1;
    wr_data = 8'h41; step();
    wr_data = 8'h42; step();
    wr_data = 8'h43; step();
    wr_valid = 1'b0;
    chk("t1_count", 32'(count), 3);
    chk("t1_valid", 32'(rd_valid), 1);
    chk("t1_head", 32'(rd_data), 32'h41);
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t1_order", 32'(rd_data), 32'h41 + 32'(i));
      step();
    end
    rd_ready = 1'b0;
    chk("t1_empty", 32'(empty), 1);
    chk("t1_valid_low", 32'(rd_valid), 0);

    // Fill to full, watch afull threshold, then drop one
    wr_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'(i);
      step();
      chk("t2_count", 32'(count), 32'(i + 1));
      chk("t2_afull", 32'(afull), (i + 1 >= 12) ? 1 : 0);
    end
    chk("t2_full", 32'(full), 1);
    chk("t2_ovf_before", 32'(overflow), 0);
    wr_data = 8'hFF; step();
    wr_valid = 1'b0;
    chk("t2_ovf", 32'(overflow), 1);
    chk("t2_count_drop", 32'(count), 16);
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t2_drain", 32'(rd_data), 32'(i));
      step();
    end
    rd_ready = 1'b0;
    chk("t2_empty", 32'(empty), 1);
    chk("t2_ovf_held", 32'(overflow), 1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("t2_ovf_clr", 32'(overflow), 0);

    // Full again: clear vs drop in same cycle, then push+pop on full
    wr_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'h10 + 8'(i);
      step();
    end
    wr_data = 8'hEE; ovf_clr = 1'b1; step();
    ovf_clr = 1'b0;
    chk("t3_drop_wins", 32'(overflow), 1);
    wr_valid = 1'b0; ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("t3_ovf_clr", 32'(overflow), 0);
    wr_valid = 1'b1; wr_data = 8'hAA; rd_ready = 1'b1; step();
    wr_valid = 1'b0; rd_ready = 1'b0;
    chk("t3_count", 32'(count), 16);
    chk("t3_full", 32'(full), 1);
    chk("t3_ovf", 32'(overflow), 0);
    rd_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk("t3_drain", 32'(rd_data), 32'h10 + 32'(i));
      step();
    end
    chk("t3_last", 32'(rd_data), 32'hAA);
    step();
    rd_ready = 1'b0;
    chk("t3_empty", 32'(empty), 1);

    // Fall-through latency with rd_ready held
    wr_valid = 1'b1; wr_data = 8'h55; rd_ready = 1'b1;
    chk("t4_valid_wrcyc", 32'(rd_valid), 0);
    step();
    wr_valid = 1'b0;
    chk("t4_valid_next", 32'(rd_valid), 1);
    chk("t4_data", 32'(rd_data), 32'h55);
    chk("t4_count1", 32'(count), 1);
    step();
    rd_ready = 1'b0;
    chk("t4_count0", 32'(count), 0);
    chk("t4_empty", 32'(empty), 1);

    // Mid-stream reset
    wr_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_data = 8'hC0 + 8'(i);
      step();
    end
    chk("t5_count10", 32'(count), 10);
    rstb = 1'b1; step(); rstb = 1'b0;
    wr_valid = 1'b0;
    chk("t5_count", 32'(count), 0);
    chk("t5_empty", 32'(empty), 1);
    chk("t5_ovf", 32'(overflow), 0);
    chk("t5_valid", 32'(rd_valid), 0);
    wr_valid = 1'b1; wr_data = 8'h77; step(); wr_valid = 1'b0;
    chk("t5_first", 32'(rd_data), 32'h77);
    chk("t5_count1", 32'(count), 1);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    chk("t5_empty2", 32'(empty), 1);

    // Idle timeout
    wr_valid = 1'b1; wr_data = 8'h88; step(); wr_valid = 1'b0;
`ifdef UART_RX_FIFO_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("t6_timeout", 32'(timeout), (k == 8) ? 1 : 0);
    end
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    chk("t6_timeout_pop", 32'(timeout), 0);
`else
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k % 5 == 0) chk("t6_timeout_off", 32'(timeout), 0);
    end
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
`endif
    chk("t6_empty", 32'(empty), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Byte buffer sitting directly downstream of the UART receiver. Captures each received byte, signalled by the receiver's single-cycle data-valid pulse, into a circular FIFO. Presents bytes to the consumer through a first-word-fall-through valid/ready interface. Reports fill level, almost-full and a sticky overflow flag, so that bursts on RxD are not lost while the consumer is busy.

Parameters:
DATA_W, 8, width of one stored byte/word
DEPTH_LOG2, 4, log2 of FIFO depth (default depth 16 entries)
AFULL_THRESH, 12, count at or above which afull_o asserts (1..2**DEPTH_LOG2)
TIMEOUT_CYC, 1024, idle-timeout length in clk_i cycles (used only with UART_RX_FIFO_TIMEOUT_EN)

Ports:
clk_i  in  1  system clock, all logic on rising edge
rstb_i  in  1  reset, synchronous, active-high
wr_data_i  in  DATA_W  byte from the receiver's data output
wr_valid_i  in  1  one-cycle write strobe from the receiver's data-valid output
rd_data_o  out  DATA_W  head-of-FIFO byte, valid while rd_valid_o=1
rd_valid_o  out  1  FIFO non-empty
rd_ready_i  in  1  consumer accepts head byte this cycle
count_o  out  DEPTH_LOG2+1  current number of stored entries
empty_o  out  1  count_o==0
full_o  out  1  count_o==2**DEPTH_LOG2
afull_o  out  1  count_o>=AFULL_THRESH
overflow_o  out  1  sticky: a write was dropped
ovf_clr_i  in  1  clears overflow_o
timeout_o  out  1  idle-timeout flag (see Optional Feature)

Behaviour:
- Reset (rstb_i=1 at an edge): wr/rd pointers=0, count_o=0, empty_o=1, full_o=0, afull_o=0, rd_valid_o=0, overflow_o=0, timeout_o=0. rd_data_o is don't-care while empty. Memory contents are not reset. Reset takes effect mid-operation and discards all stored bytes.
- Pop: rd_valid_o && rd_ready_i at an edge. rd pointer advances and the next entry appears on rd_data_o in the following cycle. rd_ready_i while empty is ignored.
- Push: wr_valid_i at an edge and (not full, or full with a pop in the same cycle). Byte is written at the wr pointer and the pointer advances.
- Drop: wr_valid_i && full_o && no pop. Byte is discarded, FIFO state is unchanged, overflow_o=1 from the next cycle.
- overflow_o holds until ovf_clr_i=1 at an edge. If a clear and a new drop occur in the same cycle, the drop wins (stays 1).
- Simultaneous push and pop: count unchanged, both pointers advance.
- Push into an empty FIFO: rd_valid_o rises the cycle after the write edge (1-cycle latency). A byte is never visible in its own write cycle.
- Pointers wrap modulo 2**DEPTH_LOG2. count_o, empty_o, full_o and afull_o are registered and consistent with each other every cycle.
- rd_data_o is driven from memory at the rd pointer (FWFT). It is stable while rd_valid_o=1 and no pop occurs.
- Ordering is strict FIFO. No byte is duplicated or reordered.
- Upstream can strobe at most once per byte time, but the block must accept wr_valid_i on consecutive cycles.

Optional Feature:
Macro UART_RX_FIFO_TIMEOUT_EN.
- Defined: an idle counter clears on any push, on reset, and while the FIFO is empty. Otherwise it increments each cycle, saturating.
- timeout_o=1 when the FIFO is non-empty and the counter has reached TIMEOUT_CYC. It clears on the next push or when the FIFO becomes empty. A pop alone does not clear it.
- Use: flushes partial messages to the consumer.
- Not defined: timeout_o is tied 0 and no counter logic is generated.

Test Plan:
- Reset then 3 pushes 0x41,0x42,0x43 with rd_ready_i=0 -> count_o=3, rd_valid_o=1, rd_data_o=0x41. Then rd_ready_i=1 for 3 cycles -> 0x41,0x42,0x43 in order, empty_o=1 after.
- 16 pushes 0x00..0x0F with no pop -> full_o=1, afull_o=1 from the 12th write onward. A 17th push of 0xFF -> dropped, overflow_o=1. Drain returns 0x00..0x0F. Pulse ovf_clr_i -> overflow_o=0.
- Full FIFO, push 0xAA with rd_ready_i=1 in the same cycle -> count stays 16, overflow_o=0, 0xAA is read out last.
- Push 0x55 into empty FIFO with rd_ready_i held 1 -> rd_valid_o=0 in the write cycle, 1 the next cycle, popped then; count_o returns to 0.
- Fill 10 entries, assert rstb_i one cycle mid-stream -> count_o=0, empty_o=1, overflow_o=0. A subsequent push of 0x77 is read back as the first byte.
- With UART_RX_FIFO_TIMEOUT_EN, TIMEOUT_CYC=8: push 1 byte, idle -> timeout_o=1 at the 8th idle cycle. Pop -> timeout_o=0. Without the macro, timeout_o stays 0 throughout.
